ring_seq_monitor: RTL and testbench

Receive-side checker for the N-bit one-hot ring counter code. It samples a ring bus on each qualified cycle and decodes the one-hot value to a binary index. It verifies that each step follows the counter's rotation (index sequence 0, N-1, N-2, ..., 1, 0), locks once the sequence is stable, and counts errors. It sits downstream of any ring counter as a decoder and health monitor.

---
 rtl/ring_seq_monitor.sv | 149 ++++++++++++++
 tb/tb_ring_seq_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ring_seq_monitor.sv
// ring_seq_monitor: decodes a one-hot ring code and checks its rotation.
// Locks after LOCK_CNT in-sequence steps and keeps a saturating error count.
module ring_seq_monitor #(
   parameter int N        = 4,
   parameter int IDX_W    = 2,
   parameter int LOCK_CNT = 2,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     ring_in,
   input  logic             ring_vld,
   output logic [IDX_W-1:0] idx,
   output logic             idx_vld,
   output logic             onehot_err,
   output logic             seq_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic {
      HUNT,
      LOCKED
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
   localparam logic [3:0]       LCNT = 4'(LOCK_CNT);
   localparam logic [N-1:0]     ONE  = N'(1);

   state_t           state, state_n;
   logic [3:0]       mcnt, mcnt_n;
   logic [IDX_W-1:0] prev, prev_n;
   logic             has_prev, has_prev_n;

   logic [IDX_W-1:0] idx_n;
   logic             idx_vld_n;
   logic             onehot_err_n;
   logic             seq_err_n;
   logic             locked_n;
   logic [ERR_W-1:0] err_cnt_n;

   logic             is_onehot;
   logic [IDX_W-1:0] dec;
   logic [IDX_W-1:0] exp_idx;
   logic             in_seq;
   logic [3:0]       mcnt_inc;
   logic [ERR_W-1:0] err_inc;

   // Decode the sample and derive the expected successor of prev.
   always_comb begin
      dec = '0;
      for (int i = 0; i < N; i++) begin
         if (ring_in[i]) dec = IDX_W'(i);
      end
      is_onehot = (ring_in != '0) &&
                  ((ring_in & (ring_in - ONE)) == '0);
      exp_idx   = (prev == '0) ? LAST : prev - 1'b1;
      in_seq    = (dec == exp_idx);
      mcnt_inc  = mcnt + 4'd1;
      err_inc   = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_n      = state;
      mcnt_n       = mcnt;
      prev_n       = prev;
      has_prev_n   = has_prev;
      idx_n        = idx;
      idx_vld_n    = 1'b0;
      onehot_err_n = 1'b0;
      seq_err_n    = 1'b0;
      locked_n     = locked;
      err_cnt_n    = err_cnt;

      if (ring_vld) begin
         if (!is_onehot) begin
            onehot_err_n = 1'b1;
            err_cnt_n    = err_inc;
            state_n      = HUNT;
            mcnt_n       = '0;
            has_prev_n   = 1'b0;
            locked_n     = 1'b0;
         end else begin
            idx_vld_n  = 1'b1;
            idx_n      = dec;
            prev_n     = dec;
            has_prev_n = 1'b1;
            unique case (state)
               HUNT: begin
                  if (!has_prev) begin
                     mcnt_n = '0;
                  end else if (in_seq) begin
                     mcnt_n = mcnt_inc;
                     if (mcnt_inc == LCNT) begin
                        state_n  = LOCKED;
                        locked_n = 1'b1;
                     end
                  end else begin
                     mcnt_n = '0;
                  end
               end
               LOCKED: begin
                  if (!in_seq) begin
                     seq_err_n = 1'b1;
                     err_cnt_n = err_inc;
                     state_n   = HUNT;
                     mcnt_n    = '0;
                     locked_n  = 1'b0;
                  end
               end
               default: begin
                  state_n  = HUNT;
                  mcnt_n   = '0;
                  locked_n = 1'b0;
               end
            endcase
         end
      end
   end

   // State and output registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         mcnt       <= '0;
         prev       <= '0;
         has_prev   <= 1'b0;
         idx        <= '0;
         idx_vld    <= 1'b0;
         onehot_err <= 1'b0;
         seq_err    <= 1'b0;
         locked     <= 1'b0;
         err_cnt    <= '0;
      end else begin
         state      <= state_n;
         mcnt       <= mcnt_n;
         prev       <= prev_n;
         has_prev   <= has_prev_n;
         idx        <= idx_n;
         idx_vld    <= idx_vld_n;
         onehot_err <= onehot_err_n;
         seq_err    <= seq_err_n;
         locked     <= locked_n;
         err_cnt    <= err_cnt_n;
      end
   end

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Scoreboard bench for ring_seq_monitor: reference model feeds a queue,
// a monitor pops one expectation per cycle and compares.
module tb_ring_seq_monitor;

   logic       clk;
   logic       rst;
   logic [3:0] ring_in;
   logic       ring_vld;

   logic [1:0] idx, idx_s;
   logic       idx_vld, idx_vld_s;
   logic       onehot_err, onehot_err_s;
   logic       seq_err, seq_err_s;
   logic       locked, locked_s;
   logic [7:0] err_cnt;
   logic [1:0] err_cnt_s;

   ring_seq_monitor #(.N(4), .IDX_W(2), .LOCK_CNT(2), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld),
      .idx(idx), .idx_vld(idx_vld), .onehot_err(onehot_err),
      .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
   );

   ring_seq_monitor #(.N(4), .IDX_W(2), .LOCK_CNT(2), .ERR_W(2)) dut_s (
      .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld),
      .idx(idx_s), .idx_vld(idx_vld_s), .onehot_err(onehot_err_s),
      .seq_err(seq_err_s), .locked(locked_s), .err_cnt(err_cnt_s)
   );

   typedef struct {
      int idx;
      int iv;
      int oh;
      int se;
      int lk;
      int err;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   int m_idx, m_lock, m_run, m_prev, m_has, m_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // apply one cycle of stimulus and push the model's expected response
   task automatic step(input logic r, input logic v, input logic [3:0] d);
      exp_t e;
      int   pos;
      int   nxt;
      rst      = r;
      ring_vld = v;
      ring_in  = d;
      e.iv = 0; e.oh = 0; e.se = 0;
      if (r) begin
         m_idx = 0; m_lock = 0; m_run = 0; m_prev = 0; m_has = 0; m_err = 0;
      end else if (v) begin
         if ($countones(d) != 1) begin
            e.oh = 1; m_err++;
            m_lock = 0; m_run = 0; m_has = 0;
         end else begin
            pos = 0;
            for (int i = 0; i < 4; i++) if (d[i]) pos = i;
            nxt = (m_prev + 3) % 4;
            e.iv = 1; m_idx = pos;
            if (m_lock == 0) begin
               if (m_has == 0) m_run = 0;
               else if (pos == nxt) begin
                  m_run++;
                  if (m_run == 2) m_lock = 1;
               end else m_run = 0;
            end else if (pos != nxt) begin
               e.se = 1; m_err++; m_lock = 0; m_run = 0;
            end
            m_prev = pos; m_has = 1;
         end
      end
      e.idx = m_idx; e.lk = m_lock; e.err = m_err;
      q.push_back(e);
      @(negedge clk);
   endtask

   function automatic logic [3:0] oh(input int p);
      logic [3:0] t;
      t = 4'b0001 << p;
      return t;
   endfunction

   // monitor: one expectation per clock, sampled after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("idx", int'(idx), e.idx);
            chk("idx_vld", int'(idx_vld), e.iv);
            chk("onehot_err", int'(onehot_err), e.oh);
            chk("seq_err", int'(seq_err), e.se);
            chk("locked", int'(locked), e.lk);
            chk("err_cnt", int'(err_cnt), sat(e.err, 255));
            chk("err_cnt_sat2", int'(err_cnt_s), sat(e.err, 3));
            chk("locked_sat2", int'(locked_s), e.lk);
         end
      end
   end

   initial begin
      int r;
      int p;
      rst = 1'b1; ring_vld = 1'b0; ring_in = '0;
      m_idx = 0; m_lock = 0; m_run = 0; m_prev = 0; m_has = 0; m_err = 0;
      // 1: clean rotation, lock on third sample
      step(1, 0, 4'b0000);
      step(0, 1, 4'b0001);
      step(0, 1, 4'b1000);
      step(0, 1, 4'b0100);
      step(0, 1, 4'b0010);
      step(0, 1, 4'b0001);
      // 2: out-of-sequence while locked, relock from new reference
      step(0, 1, 4'b1000);
      step(0, 1, 4'b0100);
      step(0, 1, 4'b0100);
      step(0, 1, 4'b0010);
      step(0, 1, 4'b0001);
      // 3: non-one-hot samples while locked
      step(0, 1, 4'b0000);
      step(0, 1, 4'b0100);
      step(0, 1, 4'b0010);
      step(0, 1, 4'b0001);
      step(0, 1, 4'b0110);
      step(0, 1, 4'b1000);
      step(0, 1, 4'b0100);
      step(0, 1, 4'b0010);
      // 4: qualifier low with garbage, then correct successor
      step(0, 0, 4'b1111);
      step(0, 0, 4'b0000);
      step(0, 0, 4'b1000);
      step(0, 1, 4'b0001);
      // 5: saturation on the 2-bit counter
      step(1, 0, 4'b0000);
      for (int i = 0; i < 5; i++) step(0, 1, 4'b1111);
      // 6: reset while locked with err_cnt=2
      step(1, 0, 4'b0000);
      step(0, 1, 4'b0011);
      step(0, 1, 4'b0000);
      step(0, 1, 4'b0001);
      step(0, 1, 4'b1000);
      step(0, 1, 4'b0100);
      step(1, 1, 4'b0010);
      step(0, 1, 4'b1000);
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) step(1, 1'($urandom), 4'($urandom));
         else if (r < 12) step(0, 0, 4'($urandom));
         else if (r < 20) step(0, 1, 4'($urandom));
         else if (r < 30) begin
            p = $urandom_range(0, 3);
            step(0, 1, oh(p));
         end else begin
            p = (m_has != 0) ? (m_prev + 3) % 4 : $urandom_range(0, 3);
            step(0, 1, oh(p));
         end
      end
      step(0, 0, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
